mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the 32-bit multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALUOp consumed by the ALU control decoder (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 funct-decoded, 111 sltu).
- Consumes that decoder's JR flag, the ALU zero flag and a memory ready handshake.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- jr  in  1  JR flag from ALU control; sampled only in EXEC_R.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- iord  out  1  0 PC address, 1 ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- reg_dst  out  2  00 rt, 01 rd, 10 r31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 sext imm<<2.
- alu_op  out  3  ALUOp to ALU control.
- state  out  4  current state, for debug.
- illegal  out  1  one-cycle registered pulse on an unknown opcode.
- instr_count  out  COUNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0): state=FETCH, illegal=0, instr_count=0. All control outputs are forced 0 while rst_n is low.
- Outputs are combinational from state; write enables are also qualified by inputs as listed. Any output not listed for a state is 0.
- Opcodes:
  - R 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - bne 000101
  - addi 001000
  - slti 001010
  - sltiu 001011
  - andi 001100
  - ori 001101
  - xori 001110
  - j 000010
  - jal 000011
- Encoding and states:
  - 0 FETCH: mem_read=1, alu_src_b=01, alu_op=000. If mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise hold with no writes.
  - 1 DECODE: alu_src_b=11, alu_op=000 (branch target). Next state:
    - R → EXEC_R
    - lw/sw → MEMADR
    - beq/bne → BRANCH
    - I-ALU → EXEC_I
    - j/jal → JUMP
    - unknown → FETCH, with illegal=1 next cycle
  - 2 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. lw → MEMRD, sw → MEMWR.
  - 3 MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
  - 4 MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01 → FETCH.
  - 5 MEMWR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
  - 6 EXEC_R: alu_src_a=1, alu_op=110.
    - jr=1: pc_write=1, pc_src=11 → FETCH.
    - Otherwise → RWB.
  - 7 RWB: reg_write=1, reg_dst=01 → FETCH.
  - 8 BRANCH: alu_src_a=1, alu_op=001, pc_src=01. pc_write=(beq&zero)|(bne&~zero) → FETCH.
  - 9 EXEC_I: alu_src_a=1, alu_src_b=10. alu_op by opcode: addi 000, andi 010, ori 011, xori 100, slti 101, sltiu 111 → IWB.
  - 10 IWB: reg_write=1, reg_dst=00 → FETCH.
  - 11 JUMP: pc_write=1, pc_src=10. jal also asserts reg_write=1, reg_dst=10, mem_to_reg=10 → FETCH.
  - Codes 12-15: go to FETCH; no outputs asserted.
- Latencies with zero-wait memory:
  - R: 4 cycles
  - jr: 3 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - I-ALU: 4 cycles
  - jump: 3 cycles
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- mem_read/mem_write stay asserted, and the address stays stable, for the entire wait.
- instr_count increments by 1 on each transition into FETCH from any state other than FETCH, DECODE (illegal) or codes 12-15. It wraps modulo 2^COUNT_W.
- illegal is not sticky; it does not increment the count.
- Reset mid-instruction or mid-wait: immediate return to FETCH. Memory requests drop asynchronously; the counter clears.

Test Plan:
- Reset asserted mid-MEMRD with mem_ready=0 → state=0, mem_read=0, instr_count=0 immediately; first fetch begins after release.
- R add (opcode 000000, jr=0), mem_ready=1 → states 0,1,6,7,0; alu_op=110 in EXEC_R; reg_write=1, reg_dst=01 in RWB; instr_count +1.
- lw with mem_ready low 3 cycles in MEMRD → mem_read=1, iord=1 held 4 cycles; MEMWB asserts mem_to_reg=01; 8 cycles total.
- beq zero=1 → pc_write=1, pc_src=01 in BRANCH. bne zero=1 → pc_write=0. Both return to FETCH after 3 cycles.
- jr (opcode 000000, jr=1) → pc_write=1, pc_src=11 in EXEC_R, RWB skipped. jal → reg_write=1, reg_dst=10, mem_to_reg=10 in JUMP.
- Opcode 111111 → DECODE → FETCH; illegal=1 for exactly one cycle; instr_count unchanged. ori → alu_op=011 in EXEC_I.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the 32-bit multicycle MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, and counts retired instructions.
module mips_multicycle_ctrl #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               jr,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_op,
   output logic [3:0]         state,
   output logic               illegal,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6, S_RWB   = 4'd7,
      S_BRANCH = 4'd8,  S_EXEC_I = 4'd9,  S_IWB    = 4'd10, S_JUMP = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011,
                          OP_SW   = 6'b101011, OP_BEQ  = 6'b000100,
                          OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                          OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
                          OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                          OP_XORI = 6'b001110, OP_J    = 6'b000010,
                          OP_JAL  = 6'b000011;

   state_t               r_state;
   state_t               w_next;
   logic                 r_illegal;
   logic [COUNT_W-1:0]   r_count;
   logic                 w_retire;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_R:                     w_next = S_EXEC_R;
               OP_LW, OP_SW:             w_next = S_MEMADR;
               OP_BEQ, OP_BNE:           w_next = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_SLTIU,
               OP_ANDI, OP_ORI, OP_XORI: w_next = S_EXEC_I;
               OP_J, OP_JAL:             w_next = S_JUMP;
               default:                  w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC_R: w_next = jr ? S_FETCH : S_RWB;
         S_EXEC_I: w_next = S_IWB;
         default:  w_next = S_FETCH;
      endcase
   end

   // An instruction retires when a real execution state hands back to FETCH.
   assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                     (r_state != S_DECODE) && (r_state <= S_JUMP);

   // NOTE: state registers use non-blocking assignments and reset asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state   <= w_next;
         r_illegal <= (r_state == S_DECODE) && (w_next == S_FETCH);
         if (w_retire) r_count <= r_count + COUNT_W'(1);
      end
   end

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'b01;
            end
            S_MEMWR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b110;
               pc_write  = jr;
               pc_src    = jr ? 2'b11 : 2'b00;
            end
            S_RWB: begin
               reg_write = 1'b1;
               reg_dst   = 2'b01;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b001;
               pc_src    = 2'b01;
               pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               case (opcode)
                  OP_ANDI:  alu_op = 3'b010;
                  OP_ORI:   alu_op = 3'b011;
                  OP_XORI:  alu_op = 3'b100;
                  OP_SLTI:  alu_op = 3'b101;
                  OP_SLTIU: alu_op = 3'b111;
                  default:  alu_op = 3'b000;
               endcase
            end
            S_IWB: reg_write = 1'b1;
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
               if (opcode == OP_JAL) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'b10;
                  mem_to_reg = 2'b10;
               end
            end
            default: ;
         endcase
      end
   end

   assign state       = r_state;
   assign illegal     = r_illegal;
   assign instr_count = r_count;

endmodule
